// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM and MEM/WB registers, data memory
// for lw/sw, and a combinational forwarding tap for the hazard unit.
module mem_stage #(
  parameter int          DM_WORDS = 1024,
  parameter logic [4:0]  RA_JAL   = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  ex_op,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_wa,
  input  logic [31:0] ex_pc,
  output logic        mem_fwd_valid,
  output logic [4:0]  mem_fwd_wa,
  output logic [31:0] mem_fwd_data,
  output logic        wb_we,
  output logic [4:0]  wb_wa,
  output logic [31:0] wb_wd,
  output logic [31:0] wb_pc
);
  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wa;
    logic [31:0] pc;
  } exmem_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } memwb_t;

  exmem_t em_q, em_d;
  memwb_t mw_q, mw_d;
  logic [31:0] dm_q [DM_WORDS];

  logic          cls_alu, cls_load, cls_link, writes;
  logic [4:0]    eff_wa;
  logic [31:0]   link_pc;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   ld_data;
  logic          st_en;
  logic          unused_lsb;

  // Class decode of the instruction currently in MEM.
  always_comb begin
    cls_alu  = ((em_q.op == OP_R) && ((em_q.funct == FN_ADDU) ||
                (em_q.funct == FN_SUBU) || (em_q.funct == FN_SLL))) ||
               (em_q.op == OP_ORI) || (em_q.op == OP_LUI);
    cls_load = (em_q.op == OP_LW);
    cls_link = (em_q.op == OP_JAL);
    eff_wa   = cls_link ? RA_JAL : em_q.wa;
    writes   = (cls_alu || cls_load || cls_link) && (eff_wa != 5'd0);
    link_pc  = em_q.pc + 32'd8;
  end

  // Byte-address bits [1:0] are ignored; anything above the memory window is out of range.
  assign idx        = em_q.alu[AW+1:2];
  assign in_range   = (em_q.alu[31:AW+2] == '0);
  assign unused_lsb = ^em_q.alu[1:0];
  assign ld_data    = in_range ? dm_q[idx] : 32'd0;
  assign st_en      = (em_q.op == OP_SW) && in_range && !stall;

  assign mem_fwd_valid = (cls_alu || cls_link) && (eff_wa != 5'd0);
  assign mem_fwd_wa    = eff_wa;
  assign mem_fwd_data  = cls_link ? link_pc : em_q.alu;

  always_comb begin
    em_d = em_q;
    if (flush) begin
      em_d = '0;
    end else if (!stall) begin
      em_d.op    = ex_op;
      em_d.funct = ex_funct;
      em_d.alu   = ex_alu;
      em_d.rt    = ex_rt_data;
      em_d.wa    = ex_wa;
      em_d.pc    = ex_pc;
    end
  end

  always_comb begin
    mw_d = '0;
    if (!stall) begin
      mw_d.we = writes;
      mw_d.wa = eff_wa;
      mw_d.wd = cls_load ? ld_data : (cls_link ? link_pc : em_q.alu);
      mw_d.pc = em_q.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      em_q <= '0;
      mw_q <= '0;
    end else begin
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= 32'd0;
    end else if (st_en) begin
      dm_q[idx] <= em_q.rt;
    end
  end

  assign wb_we = mw_q.we;
  assign wb_wa = mw_q.wa;
  assign wb_wd = mw_q.wd;
  assign wb_pc = mw_q.pc;
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against an instruction-level model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [5:0]  ex_op, ex_funct;
  logic [31:0] ex_alu, ex_rt_data, ex_pc;
  logic [4:0]  ex_wa;
  logic        mem_fwd_valid, wb_we;
  logic [4:0]  mem_fwd_wa, wb_wa;
  logic [31:0] mem_fwd_data, wb_wd, wb_pc;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [5:0] R = 6'h00, ORI = 6'h0d, LW = 6'h23, SW = 6'h2b,
                         BEQ = 6'h04, LUI = 6'h0f, JAL = 6'h03;
  localparam logic [5:0] ADDU = 6'h21, SUBU = 6'h23, JR = 6'h08, SLL = 6'h00;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_op(ex_op), .ex_funct(ex_funct), .ex_alu(ex_alu), .ex_rt_data(ex_rt_data),
    .ex_wa(ex_wa), .ex_pc(ex_pc),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_wa(mem_fwd_wa), .mem_fwd_data(mem_fwd_data),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_pc(wb_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op, funct;
    logic [31:0] alu, rt;
    logic [4:0]  wa;
    logic [31:0] pc;
  } ins_t;

  // Model state: the instruction sitting in MEM and the memory contents.
  ins_t        m_in;
  logic [31:0] m_dm [1024];

  function automatic ins_t bubble();
    ins_t b;
    b.op = 0; b.funct = 0; b.alu = 0; b.rt = 0; b.wa = 0; b.pc = 0;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // What the instruction would produce if it retired now.
  task automatic outcome(input ins_t i, output logic we, output logic [4:0] wa,
                         output logic [31:0] wd, output logic fv, output logic [31:0] fd);
    logic gives_alu, is_lw, is_jal;
    gives_alu = (i.op == R && (i.funct == ADDU || i.funct == SUBU || i.funct == SLL))
                || i.op == ORI || i.op == LUI;
    is_lw  = (i.op == LW);
    is_jal = (i.op == JAL);
    wa = is_jal ? 5'd31 : i.wa;
    if (is_lw)       wd = (i.alu < 32'h1000) ? m_dm[i.alu >> 2] : 32'd0;
    else if (is_jal) wd = i.pc + 8;
    else             wd = i.alu;
    we = (gives_alu || is_lw || is_jal) && wa != 0;
    fv = (gives_alu || is_jal) && wa != 0;
    fd = is_jal ? i.pc + 8 : i.alu;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] wa, input logic [31:0] pc);
    ex_op = op; ex_funct = fn; ex_alu = alu; ex_rt_data = rt; ex_wa = wa; ex_pc = pc;
  endtask

  // One clock: check the tap, advance the model, then check MEM/WB after the edge.
  task automatic cycle();
    logic we, fv; logic [4:0] wa; logic [31:0] wd, fd, pc;
    ins_t nxt;
    outcome(m_in, we, wa, wd, fv, fd);
    chk("fwd_valid", {31'd0, mem_fwd_valid}, {31'd0, fv});
    chk("fwd_wa", {27'd0, mem_fwd_wa}, {27'd0, wa});
    chk("fwd_data", mem_fwd_data, fd);
    pc = m_in.pc;
    if (reset || stall) we = 1'b0;
    if (!reset && !stall && m_in.op == SW && m_in.alu < 32'h1000)
      m_dm[m_in.alu >> 2] = m_in.rt;
    nxt.op = ex_op; nxt.funct = ex_funct; nxt.alu = ex_alu;
    nxt.rt = ex_rt_data; nxt.wa = ex_wa; nxt.pc = ex_pc;
    if (reset) begin
      m_in = bubble();
      for (int k = 0; k < 1024; k++) m_dm[k] = 0;
    end else if (flush) m_in = bubble();
    else if (!stall) m_in = nxt;
    @(posedge clk); #1;
    chk("wb_we", {31'd0, wb_we}, {31'd0, we});
    if (reset) begin
      chk("rst_wb_wa", {27'd0, wb_wa}, 32'd0);
      chk("rst_wb_wd", wb_wd, 32'd0);
      chk("rst_wb_pc", wb_pc, 32'd0);
    end else if (we) begin
      chk("wb_wa", {27'd0, wb_wa}, {27'd0, wa});
      chk("wb_wd", wb_wd, wd);
      chk("wb_pc", wb_pc, pc);
    end
  endtask

  task automatic nop(); drive(R, SLL, 0, 0, 0, 0); endtask

  initial begin
    m_in = bubble();
    for (int k = 0; k < 1024; k++) m_dm[k] = 32'hx;
    reset = 1; stall = 0; flush = 0; nop();
    #1;
    cycle();
    // Dirty the memory, then reset again and confirm every word reads back 0.
    reset = 0;
    for (int k = 0; k < 8; k++) begin drive(SW, 0, k*4, $urandom, 0, 0); cycle(); end
    reset = 1; stall = 1; flush = 1; drive(SW, 0, 0, 32'h1234, 0, 0); cycle();
    reset = 0; stall = 0; flush = 0; nop(); cycle();
    chk("rst_fwd_valid", {31'd0, mem_fwd_valid}, 32'd0);
    chk("rst_fwd_data", mem_fwd_data, 32'd0);
    for (int k = 0; k < 1024; k++) begin drive(LW, 0, k*4, 0, 5'd1 + 5'(k % 30), k*4); cycle(); end
    nop(); cycle();

    // sw then lw of the same word.
    drive(SW, 0, 32'h10, 32'hDEADBEEF, 0, 32'h100); cycle();
    drive(LW, 0, 32'h10, 0, 8, 32'h104); cycle();
    nop(); cycle();
    chk("sw_lw_wd", wb_wd, 32'hDEADBEEF);

    // addu forwarding and writeback, then to r0.
    drive(R, ADDU, 5, 0, 3, 32'h200); cycle();
    nop(); cycle();
    chk("addu_wd", wb_wd, 32'd5);
    drive(R, ADDU, 5, 0, 0, 32'h204); cycle();
    nop(); cycle();

    // jal links to r31; lw in MEM must not forward.
    drive(JAL, 0, 0, 0, 0, 32'h3000); cycle();
    drive(LW, 0, 32'h10, 0, 9, 32'h3008); cycle();
    chk("jal_wd", wb_wd, 32'h3008);
    chk("lw_no_fwd", {31'd0, mem_fwd_valid}, 32'd0);
    nop(); cycle();

    // Stalled sw writes once on release.
    drive(SW, 0, 32'h20, 32'h1, 0, 32'h400); cycle();
    stall = 1; nop();
    repeat (3) cycle();
    stall = 0; cycle();
    drive(LW, 0, 32'h20, 0, 4, 32'h404); cycle();
    nop(); cycle();
    chk("stall_sw_wd", wb_wd, 32'h1);

    // flush+stall drops a pending sw.
    drive(SW, 0, 32'h24, 32'h55, 0, 32'h500); cycle();
    stall = 1; flush = 1; nop(); cycle();
    stall = 0; flush = 0;
    drive(LW, 0, 32'h24, 0, 5, 32'h504); cycle();
    nop(); cycle();
    chk("flush_sw_wd", wb_wd, 32'h0);

    // Out of range and misaligned.
    drive(SW, 0, 32'h1000, 32'hAAAA5555, 0, 0); cycle();
    drive(LW, 0, 32'h1000, 0, 6, 0); cycle();
    drive(LW, 0, 32'h0, 0, 7, 0); cycle();
    drive(SW, 0, 32'h13, 32'hCAFE0013, 0, 0); cycle();
    drive(LW, 0, 32'h10, 0, 10, 0); cycle();
    nop(); cycle();
    chk("misalign_wd", wb_wd, 32'hCAFE0013);

    // Random mix over a small address window.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] ops [8];
      logic [5:0] fns [4];
      logic [31:0] a;
      ops = '{R, ORI, LW, SW, BEQ, LUI, JAL, 6'h3f};
      fns = '{ADDU, SUBU, JR, SLL};
      a = ($urandom_range(0, 9) == 0) ? $urandom : {$urandom_range(0, 15), 2'(($urandom))};
      drive(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 3)], a, $urandom,
            5'($urandom), $urandom);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 11) == 0);
      cycle();
    end
    stall = 0; flush = 0; nop(); cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
